// File: rtl/weight_slice_loader_pkg.sv
// Shared constants, FSM state type and config legality check for the fp16 weight slice loader.
package weight_slice_loader_pkg;

    localparam int DATA_WIDTH              = 16;
    localparam int KERNEL_SIZE_MAX         = 5;
    localparam int WEIGHT_WRITE_ADDR_WIDTH = 5;
    localparam int SLICE_MAX               = 4;
    localparam int LANES                   = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
    localparam int LANE_IDX_W              = 5;
    localparam int DIN_WIDTH               = LANES * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

    function automatic logic cfg_legal(input logic [2:0] ks,
                                       input logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] sc);
        return (ks != 3'd0) && (int'(ks) <= KERNEL_SIZE_MAX) &&
               (sc != '0) && (int'(sc) <= SLICE_MAX);
    endfunction

endpackage

// File: rtl/weight_slice_loader_buffer.sv
// weight_slice_buffer: 25-lane fp16 register array with clear, indexed lane write and flat output.
module weight_slice_buffer
    import weight_slice_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic                  i_we,
    input  logic [LANE_IDX_W-1:0] i_idx,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DIN_WIDTH-1:0]  o_flat
);

    logic [DATA_WIDTH-1:0] r_lane [LANES];

    // Clear wins over a same-cycle write so an aborted final word never lands.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            for (int n = 0; n < LANES; n++) begin
                r_lane[n] <= '0;
            end
        end else if (i_we && (int'(i_idx) < LANES)) begin
            r_lane[i_idx] <= i_data;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_flat
        assign o_flat[g*DATA_WIDTH +: DATA_WIDTH] = r_lane[g];
    end

endmodule

// File: rtl/weight_slice_loader.sv
// Packs a serial fp16 weight stream into 25-lane slices and writes one slice per RAM address.
// Optional WEIGHT_LOAD_ABORT_EN adds an abort input that drops the job back to IDLE.
module weight_slice_loader
    import weight_slice_loader_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [2:0]                         kernel_size,
    input  logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] slice_count,
`ifdef WEIGHT_LOAD_ABORT_EN
    input  logic                               abort,
`endif
    input  logic                               w_valid,
    input  logic [DATA_WIDTH-1:0]              w_data,
    output logic                               w_ready,
    output logic                               ena_w,
    output logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] addr_write,
    output logic [DIN_WIDTH-1:0]               din,
    output logic                               busy,
    output logic                               done,
    output logic                               cfg_err
);

    state_t                             r_state;
    state_t                             w_next;
    logic [LANE_IDX_W-1:0]              r_kk;
    logic [LANE_IDX_W-1:0]              r_idx;
    logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] r_slices;
    logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] r_addr;
    logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] r_addr_last;
    logic [DIN_WIDTH-1:0]               r_din_last;
    logic                               r_cfg_err;

    logic                 w_abort;
    logic                 w_legal;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_slice_end;
    logic                 w_buf_clr;
    logic                 w_buf_we;
    logic [DIN_WIDTH-1:0] w_buf;

`ifdef WEIGHT_LOAD_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_legal     = cfg_legal(kernel_size, slice_count);
    assign w_accept    = (r_state == S_LOAD) && w_valid;
    assign w_last      = (r_idx == r_kk - 5'd1);
    assign w_slice_end = (r_addr == r_slices - 1'b1);
    assign w_buf_we    = w_accept && !w_abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are decoded from the registered state; din/addr_write replay the last write outside WRITE.
    always_comb begin
        w_next     = r_state;
        w_buf_clr  = 1'b0;
        w_ready    = 1'b0;
        ena_w      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        din        = r_din_last;
        addr_write = r_addr_last;
        case (r_state)
            S_IDLE: begin
                if (start && w_legal) begin
                    w_next    = S_LOAD;
                    w_buf_clr = 1'b1;
                end
            end
            S_LOAD: begin
                w_ready = 1'b1;
                busy    = 1'b1;
                if (w_abort) begin
                    w_next    = S_IDLE;
                    w_buf_clr = 1'b1;
                end else if (w_accept && w_last) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                ena_w      = 1'b1;
                busy       = 1'b1;
                din        = w_buf;
                addr_write = r_addr;
                if (w_abort) begin
                    w_next    = S_IDLE;
                    w_buf_clr = 1'b1;
                end else if (w_slice_end) begin
                    w_next = S_DONE;
                end else begin
                    w_next    = S_LOAD;
                    w_buf_clr = 1'b1;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_kk        <= '0;
            r_idx       <= '0;
            r_slices    <= '0;
            r_addr      <= '0;
            r_addr_last <= '0;
            r_din_last  <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= (r_state == S_IDLE) && start && !w_legal;
            case (r_state)
                S_IDLE: begin
                    if (start && w_legal) begin
                        r_kk     <= {2'b00, kernel_size} * {2'b00, kernel_size};
                        r_slices <= slice_count;
                        r_idx    <= '0;
                        r_addr   <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_buf_we) begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
                S_WRITE: begin
                    r_din_last  <= w_buf;
                    r_addr_last <= r_addr;
                    if (w_next == S_LOAD) begin
                        r_addr <= r_addr + 1'b1;
                        r_idx  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cfg_err = r_cfg_err;

    weight_slice_buffer u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_buf_clr),
        .i_we   (w_buf_we),
        .i_idx  (r_idx),
        .i_data (w_data),
        .o_flat (w_buf)
    );

endmodule

// File: tb/tb_weight_slice_loader.sv
// Self-checking bench for weight_slice_loader: directed jobs plus randomized data/valid patterns.
module tb_weight_slice_loader;
    import weight_slice_loader_pkg::*;

    logic                               clk = 1'b0;
    logic                               rst_n;
    logic                               start;
    logic [2:0]                         kernel_size;
    logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] slice_count;
`ifdef WEIGHT_LOAD_ABORT_EN
    logic                               abort;
`endif
    logic                               w_valid;
    logic [DATA_WIDTH-1:0]              w_data;
    logic                               w_ready;
    logic                               ena_w;
    logic [WEIGHT_WRITE_ADDR_WIDTH-1:0] addr_write;
    logic [DIN_WIDTH-1:0]               din;
    logic                               busy;
    logic                               done;
    logic                               cfg_err;

    always #5 clk = ~clk;

    weight_slice_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .kernel_size (kernel_size),
        .slice_count (slice_count),
`ifdef WEIGHT_LOAD_ABORT_EN
        .abort       (abort),
`endif
        .w_valid     (w_valid),
        .w_data      (w_data),
        .w_ready     (w_ready),
        .ena_w       (ena_w),
        .addr_write  (addr_write),
        .din         (din),
        .busy        (busy),
        .done        (done),
        .cfg_err     (cfg_err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cfg_cnt  = 0;

    typedef struct {
        int                   addr;
        logic [DIN_WIDTH-1:0] data;
        int                   cycle;
    } wr_t;

    wr_t          wq[$];
    int           hs_cyc[$];
    int           done_cyc[$];
    logic         rdy_q[$];
    logic [15:0]  words[$];

    always @(negedge clk) begin
        cyc++;
        if (w_valid && w_ready) hs_cyc.push_back(cyc);
        if (ena_w) wq.push_back('{addr: int'(addr_write), data: din, cycle: cyc});
        if (done) done_cyc.push_back(cyc);
        if (cfg_err) cfg_cnt++;
        if (busy) rdy_q.push_back(w_ready);
    end

    task automatic chk(input string tag, input logic [DIN_WIDTH-1:0] obs, input logic [DIN_WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wq.delete();
        hs_cyc.delete();
        done_cyc.delete();
        rdy_q.delete();
        cfg_cnt = 0;
    endtask

    task automatic make_words(input int n, input bit seq, input logic [15:0] base);
        words.delete();
        for (int i = 0; i < n; i++) begin
            words.push_back(seq ? 16'(base + 16'(i)) : 16'($urandom));
        end
    endtask

    task automatic start_job(input int ks, input int sc);
        kernel_size = 3'(ks);
        slice_count = WEIGHT_WRITE_ADDR_WIDTH'(sc);
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    // mode 0: valid always high, 1: toggles every other cycle, 2: random
    task automatic feed(input int n, input int mode);
        int   i = 0;
        int   b = 0;
        logic acc;
        while (i < n && b < 4000) begin
            case (mode)
                0:       w_valid = 1'b1;
                1:       w_valid = (b % 2 == 0);
                default: w_valid = 1'($urandom_range(0, 1));
            endcase
            w_data = words[i];
            @(negedge clk);
            acc = w_valid && w_ready;
            step();
            if (acc) i++;
            b++;
        end
        w_valid = 1'b0;
        chk("feed_budget", DIN_WIDTH'(i), DIN_WIDTH'(n));
    endtask

    task automatic wait_done();
        int b = 0;
        while (done_cyc.size() == 0 && b < 200) begin
            step();
            b++;
        end
        step();
        step();
    endtask

    task automatic check_job(input string tag, input int ks, input int sc);
        int                   kk;
        logic [DIN_WIDTH-1:0] exp;
        kk = ks * ks;
        chk({tag, "_nwrites"}, DIN_WIDTH'(wq.size()), DIN_WIDTH'(sc));
        chk({tag, "_ndone"}, DIN_WIDTH'(done_cyc.size()), DIN_WIDTH'(1));
        for (int s = 0; s < sc && s < wq.size(); s++) begin
            exp = '0;
            for (int l = 0; l < kk; l++) exp[l*16 +: 16] = words[s*kk + l];
            chk($sformatf("%s_addr%0d", tag, s), DIN_WIDTH'(wq[s].addr), DIN_WIDTH'(s));
            chk($sformatf("%s_din%0d", tag, s), wq[s].data, exp);
            if (hs_cyc.size() >= (s + 1) * kk)
                chk($sformatf("%s_lat%0d", tag, s), DIN_WIDTH'(wq[s].cycle),
                    DIN_WIDTH'(hs_cyc[(s + 1) * kk - 1] + 1));
        end
        if (wq.size() > 0 && done_cyc.size() > 0)
            chk({tag, "_done_lat"}, DIN_WIDTH'(done_cyc[0]), DIN_WIDTH'(wq[wq.size() - 1].cycle + 1));
        chk({tag, "_busy_idle"}, DIN_WIDTH'(busy), DIN_WIDTH'(0));
    endtask

    task automatic run_job(input string tag, input int ks, input int sc, input int mode,
                           input bit seq, input logic [15:0] base);
        clear_log();
        make_words(ks * ks * sc, seq, base);
        start_job(ks, sc);
        feed(ks * ks * sc, mode);
        wait_done();
        check_job(tag, ks, sc);
    endtask

    task automatic check_zero_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_w_ready"}, DIN_WIDTH'(w_ready), '0);
        chk({tag, "_ena_w"}, DIN_WIDTH'(ena_w), '0);
        chk({tag, "_addr"}, DIN_WIDTH'(addr_write), '0);
        chk({tag, "_din"}, din, '0);
        chk({tag, "_busy"}, DIN_WIDTH'(busy), '0);
        chk({tag, "_done"}, DIN_WIDTH'(done), '0);
        chk({tag, "_cfg_err"}, DIN_WIDTH'(cfg_err), '0);
    endtask

    initial begin
        logic [4:0] rdy_pat;
        int         ks;
        int         sc;
        rdy_pat     = 5'b10101;
        rst_n       = 1'b0;
        start       = 1'b0;
        kernel_size = '0;
        slice_count = '0;
        w_valid     = 1'b0;
        w_data      = '0;
`ifdef WEIGHT_LOAD_ABORT_EN
        abort       = 1'b0;
`endif
        step();
        step();
        step();
        check_zero_outputs("reset");
        rst_n = 1'b1;
        step();

        run_job("ks3", 3, 2, 0, 1'b1, 16'h3C00);
        run_job("ks5", 5, 4, 1, 1'b0, 16'h0000);

        clear_log();
        start_job(6, 1);
        @(negedge clk);
        chk("cfg_ks6", DIN_WIDTH'(cfg_err), DIN_WIDTH'(1));
        chk("cfg_ks6_busy", DIN_WIDTH'(busy), '0);
        step();
        start_job(3, 0);
        @(negedge clk);
        chk("cfg_sc0", DIN_WIDTH'(cfg_err), DIN_WIDTH'(1));
        step();
        start_job(3, 5);
        @(negedge clk);
        chk("cfg_sc5", DIN_WIDTH'(cfg_err), DIN_WIDTH'(1));
        chk("cfg_sc5_busy", DIN_WIDTH'(busy), '0);
        step();
        step();
        chk("cfg_pulses", DIN_WIDTH'(cfg_cnt), DIN_WIDTH'(3));
        chk("cfg_no_write", DIN_WIDTH'(wq.size()), '0);
        chk("cfg_idle_ready", DIN_WIDTH'(w_ready), '0);

        clear_log();
        words.delete();
        words.push_back(16'h4000);
        words.push_back(16'h4200);
        words.push_back(16'h4400);
        start_job(1, 3);
        feed(3, 0);
        wait_done();
        check_job("ks1", 1, 3);
        for (int k = 0; k < 5; k++)
            chk($sformatf("ks1_ready%0d", k), DIN_WIDTH'(rdy_q[k]), DIN_WIDTH'(rdy_pat[4-k]));

        for (int j = 0; j < 3; j++) begin
            ks = int'($urandom_range(1, 5));
            sc = int'($urandom_range(1, 4));
            run_job($sformatf("rnd%0d", j), ks, sc, 2, 1'b0, 16'h0000);
        end

        clear_log();
        make_words(9, 1'b0, 16'h0000);
        start_job(3, 1);
        feed(4, 0);
        rst_n = 1'b0;
        step();
        check_zero_outputs("midrst");
        rst_n = 1'b1;
        step();
        step();
        chk("midrst_no_write", DIN_WIDTH'(wq.size()), '0);
        run_job("after_rst", 3, 1, 0, 1'b0, 16'h0000);

`ifdef WEIGHT_LOAD_ABORT_EN
        clear_log();
        make_words(18, 1'b1, 16'h5000);
        start_job(3, 2);
        feed(8, 0);
        w_valid = 1'b1;
        w_data  = words[8];
        abort   = 1'b1;
        @(negedge clk);
        chk("abort_ready", DIN_WIDTH'(w_ready), DIN_WIDTH'(1));
        step();
        abort   = 1'b0;
        w_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", DIN_WIDTH'(busy), '0);
        chk("abort_ena", DIN_WIDTH'(ena_w), '0);
        for (int k = 0; k < 5; k++) step();
        chk("abort_no_write", DIN_WIDTH'(wq.size()), '0);
        chk("abort_no_done", DIN_WIDTH'(done_cyc.size()), '0);
        run_job("after_abort", 3, 2, 0, 1'b1, 16'h6000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
